// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bus between the truth-table sweeper and its environment.
//   start       : request to begin a sweep (level-sampled)
//   exp_table   : expected truth table, bit k = F for row k = {P,Q,R}
//   f_in        : F output of the function under test
//   p_out/q_out/r_out : row drive, P is MSB of the row index
//   busy/done/pass    : sweep status, pass valid only while done=1
//   captured/mismatch : observed table and per-row error flags
interface truth_table_sweeper_if;
  logic       start;
  logic [7:0] exp_table;
  logic       f_in;
  logic       p_out;
  logic       q_out;
  logic       r_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] captured;
  logic [7:0] mismatch;

  // Sweeper side
  modport slave (
    input  start, exp_table, f_in,
    output p_out, q_out, r_out, busy, done, pass, captured, mismatch
  );

  // Environment side (drives stimulus, observes results)
  modport master (
    output start, exp_table, f_in,
    input  p_out, q_out, r_out, busy, done, pass, captured, mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 8 rows of a 3-input function in order,
// holds each row SETTLE_CYCLES cycles, samples F in a one-cycle SAMPLE
// state, and compares the observed table with an expected table latched
// at the accepted start.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : truth_table_sweeper_if.slave (start/exp_table/f_in in,
//           row drive, status and result tables out; all outputs registered)
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TBL_W = 8;
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(7);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [IDX_W-1:0]   row_q,      row_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               pass_q,     pass_d;
  logic [TBL_W-1:0]   captured_q, captured_d;
  logic [TBL_W-1:0]   mismatch_q, mismatch_d;
  logic [TBL_W-1:0]   exp_q,      exp_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= '0;
      mismatch_q <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
      exp_q      <= exp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    exp_d      = exp_q;

    case (state_q)
      // Start is only honoured when no sweep is running
      IDLE, DONE: begin
        if (bus.start) begin
          exp_d      = bus.exp_table;
          captured_d = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          idx_d      = '0;
          cnt_d      = CNT_LOAD;
          row_d      = '0;
          state_d    = SETTLE;
        end
      end

      // Counter was loaded with SETTLE_CYCLES-1, so this state lasts
      // exactly SETTLE_CYCLES cycles
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end

      SAMPLE: begin
        captured_d[idx_q] = bus.f_in;
        mismatch_d[idx_q] = bus.f_in ^ exp_q[idx_q];
        if (idx_q == LAST_ROW) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          row_d   = '0;
          pass_d  = (captured_d == exp_q);
        end else begin
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          row_d   = IDX_W'(idx_q + IDX_W'(1));
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.p_out    = row_q[2];
  assign bus.q_out    = row_q[1];
  assign bus.r_out    = row_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.captured = captured_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage that wraps the 3-input combinational `logic_function` block.
- Upstream role: drives P, Q, R through all 8 input rows in order.
- Downstream role: samples F after a settle interval, builds the 8-bit observed truth table and compares it against an expected table.
- Allows in-system, self-checking verification of the combinational function without a simulator bench.

Parameters:
- SETTLE_CYCLES, 2, number of cycles each input row is held before F is sampled (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request to begin a sweep; acted on only in IDLE or DONE.
- exp_table  input  8  expected truth table; bit k is the expected F for row k = {P,Q,R}; latched on accepted start.
- f_in  input  1  F output of the function under test.
- p_out  output  1  P drive; MSB of the row index.
- q_out  output  1  Q drive.
- r_out  output  1  R drive; LSB of the row index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid when done=1; 1 when captured equals the latched exp_table.
- captured  output  8  observed truth table; bit k is F sampled for row k.
- mismatch  output  8  per-row error flags; bit k = captured[k] XOR latched exp_table[k].

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. When rst_n=0, immediately:
  - state=IDLE, row index=0, settle counter=0
  - p_out=q_out=r_out=0, busy=0, done=0, pass=0
  - captured=0, mismatch=0, latched expected=0
- Reset asserted mid-sweep aborts the sweep with no partial result retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Outputs drive row 000, busy=0.
  - On start=1: latch exp_table, clear captured/mismatch/pass, idx=0, load settle counter, go to SETTLE, busy=1.
- SETTLE:
  - {p_out,q_out,r_out}=idx, registered, so the outputs change only on clock edges.
  - Stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE:
  - Row still driven for this one cycle.
  - At the closing edge: captured[idx]<=f_in and mismatch[idx]<=f_in^exp_q[idx].
  - If idx==7: go to DONE. Otherwise idx<=idx+1, reload the counter, go to SETTLE.
- Row timing:
  - Each row is held SETTLE_CYCLES+1 cycles.
  - Row k is captured at edge (k+1)*(SETTLE_CYCLES+1) after the start edge.
  - A full sweep takes 8*(SETTLE_CYCLES+1) cycles.
- DONE:
  - busy=0, done=1, pass=(captured==exp_q), which is equivalent to mismatch==0.
  - Drive outputs return to 000. captured and mismatch are held stable.
  - Remains in DONE indefinitely.
  - start=1 in DONE behaves as start in IDLE: done and pass drop at that edge and a new sweep begins.
- Start handling:
  - start while busy=1 is ignored; the sweep is not restarted and exp_table is not re-latched.
  - start held high continuously in DONE re-triggers a sweep immediately after each completion. This is legal.
- exp_table changes after the accepted start have no effect on the current sweep.
- Row index wrap: idx never wraps; the transition from row 7 goes to DONE only.
- f_in is sampled only in SAMPLE. Glitches during SETTLE have no effect.
- pass is meaningful only while done=1. It reads 0 otherwise.
- Implementation: a single registered FSM. The row counter is 3 bits; the settle counter is 4 bits.

Test Plan:
- Parity function: bench models F=P^Q^R, exp_table=8'h96, SETTLE_CYCLES=2. Pulse start -> rows 000..111 each held 3 cycles. done rises after the 24th edge following start, with captured=8'h96, mismatch=8'h00, pass=1, busy=0.
- Wrong expectation: same function, exp_table=8'h97 -> captured=8'h96, mismatch=8'h01, pass=0, done=1.
- Majority function with slow settle: F=PQ|PR|QR, exp_table=8'hE8, SETTLE_CYCLES=5 -> each row held 6 cycles, done after edge 48, pass=1. Changing exp_table to 8'h00 mid-sweep does not alter pass.
- Start while busy: start pulsed again at row 3 -> no restart, row sequence continuous, completion still at edge 24.
- Reset mid-sweep: rst_n driven low asynchronously (between edges) during row 4 -> p/q/r, busy, done, pass, captured and mismatch all go to 0 immediately. After release, start runs a clean full sweep.
- Re-arm from DONE: start=1 while done=1 -> done and pass drop at that edge, captured clears, and a new sweep completes with results matching the second exp_table.
